// File: rtl/vga_pkg.sv
// Shared definitions for the VGA line buffer: active-area sizes, the fill
// state machine encoding, the 8-colour palette and line-number arithmetic.
package vga_pkg;

  localparam int ACTI_H = 640;
  localparam int ACTI_V = 480;

  localparam int LINE_W = 10;
  localparam int IDX_W  = 3;

  localparam logic [10:0]       ACTI_H_W = 11'd640;
  localparam logic [10:0]       LAST_ROW = 11'd479;
  localparam logic [LINE_W-1:0] LAST_COL = 10'd639;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } fill_state_t;

  // Entry n is the 24-bit RGB colour for index n.
  localparam logic [7:0][23:0] PALETTE = {
    24'hFFFFFF,  // 7 white
    24'hFF00FF,  // 6 magenta
    24'h00FFFF,  // 5 cyan
    24'hFFFF00,  // 4 yellow
    24'h0000FF,  // 3 blue
    24'h00FF00,  // 2 green
    24'hFF0000,  // 1 red
    24'h000000   // 0 black
  };

  // Line following y, wrapping the last visible line back to line 0.
  function automatic logic [LINE_W-1:0] next_line(input logic [10:0] y);
    logic [LINE_W-1:0] r;
    if (y >= LAST_ROW) begin
      r = 10'd0;
    end else begin
      r = y[LINE_W-1:0] + 10'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_line_buffer_if.sv
// Line-fill request and upstream pixel-beat handshake between the line
// buffer (slave) and the memory fetch engine (master).
interface vga_line_buffer_if;
  import vga_pkg::*;

  logic              i_pix_valid;
  logic [IDX_W-1:0]  i_pix_data;
  logic              o_pix_ready;
  logic              o_req;
  logic [LINE_W-1:0] o_req_line;

  modport master (
    output i_pix_valid,
    output i_pix_data,
    input  o_pix_ready,
    input  o_req,
    input  o_req_line
  );

  modport slave (
    input  i_pix_valid,
    input  i_pix_data,
    output o_pix_ready,
    output o_req,
    output o_req_line
  );
endinterface

// File: rtl/vga_line_bank.sv
// One 640-entry line of 3-bit colour indices: synchronous write port,
// combinational read port. Out-of-range reads return index 0.
module vga_line_bank
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [LINE_W-1:0] waddr,
  input  logic [IDX_W-1:0]  wdata,
  input  logic [10:0]       raddr,
  output logic [IDX_W-1:0]  rdata
);

  logic [IDX_W-1:0] mem [ACTI_H];

  // Clear the whole line on reset, otherwise store one index per write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ACTI_H; i++) begin
        mem[i] <= 3'd0;
      end
    end else if (we && (waddr <= LAST_COL)) begin
      mem[waddr] <= wdata;
    end
  end

  // Zero-latency read, guarded against the blanking region.
  always_comb begin
    if (raddr < ACTI_H_W) begin
      rdata = mem[raddr[LINE_W-1:0]];
    end else begin
      rdata = 3'd0;
    end
  end

endmodule

// File: rtl/vga_line_buffer.sv
// Double-buffered VGA line store. One bank is displayed while the other is
// filled from upstream; banks swap on a line change once the fill is complete,
// otherwise the fill restarts for the new line and underflow is flagged.
module vga_line_buffer
  import vga_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [10:0]        i_x,
  input  logic [10:0]        i_y,
  vga_line_buffer_if.slave   pix,
  output logic [7:0]         o_R,
  output logic [7:0]         o_G,
  output logic [7:0]         o_B,
  output logic               o_underflow
);

  fill_state_t       state_q, state_d;
  logic [LINE_W-1:0] cnt_q, cnt_d;
  logic [LINE_W-1:0] target_q, target_d;
  logic              disp_bank_q;
  logic [10:0]       y_q;
  logic              underflow_q;

  logic              line_event;
  logic              accept;
  logic              last_beat;
  logic              swap;
  logic              underflow_set;
  logic [IDX_W-1:0]  rd0, rd1;
  logic [IDX_W-1:0]  idx;
  logic [23:0]       rgb;

  assign line_event = (i_y != y_q);
  assign accept     = (state_q == ST_FILL) && pix.i_pix_valid;
  assign last_beat  = accept && (cnt_q == LAST_COL);

  assign pix.o_pix_ready = (state_q == ST_FILL);
  assign pix.o_req       = (state_q == ST_REQ);
  assign pix.o_req_line  = target_q;
  assign o_underflow     = underflow_q;

  // The fill bank is always the one not on display.
  vga_line_bank u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && disp_bank_q),
    .waddr (cnt_q),
    .wdata (pix.i_pix_data),
    .raddr (i_x),
    .rdata (rd0)
  );

  vga_line_bank u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && !disp_bank_q),
    .waddr (cnt_q),
    .wdata (pix.i_pix_data),
    .raddr (i_x),
    .rdata (rd1)
  );

  // State, counters, bank select and the previous-line register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 10'd0;
      target_q    <= 10'd1;
      disp_bank_q <= 1'b0;
      y_q         <= 11'd0;
      underflow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      y_q      <= i_y;
      if (swap) begin
        disp_bank_q <= ~disp_bank_q;
      end else begin
        disp_bank_q <= disp_bank_q;
      end
      if (underflow_set) begin
        underflow_q <= 1'b1;
      end else begin
        underflow_q <= underflow_q;
      end
    end
  end

  // Fill FSM next-state: a completed line (even one completed this very
  // cycle) swaps on a line event; an incomplete one is abandoned.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    target_d      = target_q;
    swap          = 1'b0;
    underflow_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (line_event) begin
          underflow_set = 1'b1;
          cnt_d         = 10'd0;
          target_d      = next_line(i_y);
          state_d       = ST_REQ;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (line_event && last_beat) begin
          swap     = 1'b1;
          cnt_d    = 10'd0;
          target_d = next_line(i_y);
          state_d  = ST_REQ;
        end else if (line_event) begin
          underflow_set = 1'b1;
          cnt_d         = 10'd0;
          target_d      = next_line(i_y);
          state_d       = ST_REQ;
        end else if (last_beat) begin
          cnt_d   = 10'd0;
          state_d = ST_DONE;
        end else if (accept) begin
          cnt_d = cnt_q + 10'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_DONE: begin
        if (line_event) begin
          swap     = 1'b1;
          target_d = next_line(i_y);
          state_d  = ST_REQ;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Palette lookup of the displayed bank, blanked outside the active width.
  always_comb begin
    idx = disp_bank_q ? rd1 : rd0;
    if (i_x < ACTI_H_W) begin
      rgb = PALETTE[idx];
    end else begin
      rgb = 24'd0;
    end
  end

  assign o_R = rgb[23:16];
  assign o_G = rgb[15:8];
  assign o_B = rgb[7:0];

endmodule

// File: tb/tb_vga_line_buffer.sv
// Directed-sequence bench for vga_line_buffer with random pixel data and
// random valid gaps, checked against a line-level model of the two buffers.
module tb_vga_line_buffer;

  logic        clk;
  logic        rst;
  logic [10:0] i_x;
  logic [10:0] i_y;
  logic [7:0]  o_R, o_G, o_B;
  logic        o_underflow;

  vga_line_buffer_if pix ();

  vga_line_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .i_x         (i_x),
    .i_y         (i_y),
    .pix         (pix),
    .o_R         (o_R),
    .o_G         (o_G),
    .o_B         (o_B),
    .o_underflow (o_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: what is on screen, and what the current fill holds.
  int disp_m [640];
  int fill_m [640];
  int fill_cnt = 0;

  function automatic logic [23:0] pal(input int c);
    case (c)
      0: return 24'h000000;
      1: return 24'hFF0000;
      2: return 24'h00FF00;
      3: return 24'h0000FF;
      4: return 24'hFFFF00;
      5: return 24'h00FFFF;
      6: return 24'hFF00FF;
      7: return 24'hFFFFFF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_line(input string tag);
    int pts [8];
    logic [23:0] e;
    pts = '{0, 5, 320, 639, 640, 1500, 0, 0};
    pts[6] = int'($urandom_range(0, 639));
    pts[7] = int'($urandom_range(0, 639));
    for (int k = 0; k < 8; k++) begin
      i_x = 11'(pts[k]);
      #1;
      e = (pts[k] < 640) ? pal(disp_m[pts[k]]) : 24'h000000;
      chk(tag, {8'h00, o_R, o_G, o_B}, {8'h00, e});
    end
  endtask

  task automatic show_fill();
    for (int k = 0; k < 640; k++) disp_m[k] = fill_m[k];
    fill_cnt = 0;
  endtask

  task automatic wait_req(input string tag, input int max_cyc, output int cyc);
    cyc = 0;
    while (pix.o_req !== 1'b1 && cyc < max_cyc) begin
      tick();
      cyc++;
    end
    chk(tag, 32'(pix.o_req), 32'd1);
  endtask

  task automatic enter_fill();
    tick();
    chk("req_one_cycle", 32'(pix.o_req), 32'd0);
  endtask

  // Offer beats until n_beats are accepted; optionally change i_y on the last one.
  task automatic stream(input int n_beats, input bit rand_valid, input int fixed_data,
                        input bit y_on_last, input int new_y);
    int sent;
    int guard;
    logic v;
    logic [2:0] d;
    sent = 0;
    guard = 0;
    while (sent < n_beats && guard < 5000) begin
      v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      d = (fixed_data >= 0) ? 3'(fixed_data) : 3'($urandom_range(0, 7));
      pix.i_pix_valid = v;
      pix.i_pix_data  = d;
      if (v && y_on_last && sent == n_beats - 1) i_y = 11'(new_y);
      chk("pix_ready", 32'(pix.o_pix_ready), 32'(fill_cnt < 640));
      if (v && fill_cnt < 640) begin
        fill_m[fill_cnt] = int'(d);
        fill_cnt++;
        sent++;
      end
      tick();
      guard++;
    end
    pix.i_pix_valid = 1'b0;
    chk("stream_budget", 32'(guard < 5000), 32'd1);
  endtask

  int cyc;

  initial begin
    rst = 1'b1;
    i_x = 11'd0;
    i_y = 11'd0;
    pix.i_pix_valid = 1'b0;
    pix.i_pix_data  = 3'd0;
    for (int k = 0; k < 640; k++) begin
      disp_m[k] = 0;
      fill_m[k] = 0;
    end
    tick();
    tick();

    // Reset state: black everywhere, no request, no underflow.
    for (int x = 0; x < 640; x++) begin
      i_x = 11'(x);
      #1;
      chk("reset_rgb", {8'h00, o_R, o_G, o_B}, 32'd0);
    end
    tick();
    chk("reset_req", 32'(pix.o_req), 32'd0);
    chk("reset_underflow", 32'(o_underflow), 32'd0);
    chk("reset_ready", 32'(pix.o_pix_ready), 32'd0);

    // Release: first request is for line 1 within two cycles.
    rst = 1'b0;
    wait_req("first_req", 4, cyc);
    chk("first_req_latency", 32'(cyc >= 1 && cyc <= 2), 32'd1);
    chk("first_req_line", 32'(pix.o_req_line), 32'd1);
    enter_fill();

    // Full fill with green, then step to line 1.
    stream(640, 1'b0, 2, 1'b0, 0);
    chk("done_ready", 32'(pix.o_pix_ready), 32'd0);
    i_y = 11'd1;
    tick();
    show_fill();
    chk("full_req", 32'(pix.o_req), 32'd1);
    chk("full_req_line", 32'(pix.o_req_line), 32'd2);
    chk("full_underflow", 32'(o_underflow), 32'd0);
    i_x = 11'd5;
    #1;
    chk("full_G", 32'(o_G), 32'hFF);
    chk("full_RB", 32'({o_R, o_B}), 32'd0);
    check_line("full_rgb");
    enter_fill();

    // Backpressure: random valid gaps, then extra beats while done.
    stream(640, 1'b1, -1, 1'b0, 0);
    for (int k = 0; k < 6; k++) begin
      pix.i_pix_valid = 1'b1;
      pix.i_pix_data  = 3'($urandom_range(0, 7));
      chk("extra_ready", 32'(pix.o_pix_ready), 32'd0);
      tick();
    end
    pix.i_pix_valid = 1'b0;
    i_y = 11'd2;
    tick();
    show_fill();
    chk("bp_req", 32'(pix.o_req), 32'd1);
    chk("bp_req_line", 32'(pix.o_req_line), 32'd3);
    check_line("bp_rgb");
    enter_fill();

    // Boundary: last beat and the line change in the same cycle.
    stream(640, 1'b0, -1, 1'b1, 3);
    show_fill();
    chk("bnd_req", 32'(pix.o_req), 32'd1);
    chk("bnd_req_line", 32'(pix.o_req_line), 32'd4);
    chk("bnd_underflow", 32'(o_underflow), 32'd0);
    check_line("bnd_rgb");
    enter_fill();

    // Underflow: partial fill abandoned, display unchanged.
    stream(300, 1'b0, -1, 1'b0, 0);
    i_y = 11'd4;
    tick();
    fill_cnt = 0;
    chk("uf_req", 32'(pix.o_req), 32'd1);
    chk("uf_req_line", 32'(pix.o_req_line), 32'd5);
    chk("uf_underflow", 32'(o_underflow), 32'd1);
    check_line("uf_rgb");
    enter_fill();

    // Wrap: line 479 requests line 0; underflow stays sticky.
    stream(640, 1'b0, -1, 1'b0, 0);
    i_y = 11'd479;
    tick();
    show_fill();
    chk("wrap_req", 32'(pix.o_req), 32'd1);
    chk("wrap_req_line", 32'(pix.o_req_line), 32'((479 + 1) % 480));
    chk("wrap_underflow", 32'(o_underflow), 32'd1);
    check_line("wrap_rgb");
    enter_fill();

    // Reset mid-fill: everything clears and line 1 is requested again.
    stream(100, 1'b0, -1, 1'b0, 0);
    i_y = 11'd0;
    rst = 1'b1;
    tick();
    for (int k = 0; k < 640; k++) disp_m[k] = 0;
    fill_cnt = 0;
    chk("mid_rst_req", 32'(pix.o_req), 32'd0);
    chk("mid_rst_underflow", 32'(o_underflow), 32'd0);
    chk("mid_rst_ready", 32'(pix.o_pix_ready), 32'd0);
    check_line("mid_rst_rgb");
    rst = 1'b0;
    wait_req("rerun_req", 4, cyc);
    chk("rerun_req_line", 32'(pix.o_req_line), 32'd1);
    chk("rerun_underflow", 32'(o_underflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
